// File: rtl/fsm_host_bridge.sv
// Host-side sequencer for the nibble-serial compute FSM: loads both operands, plays an
// opcode program, then reassembles the result nibble stream into a valid/ready response.
module fsm_host_bridge #(
  parameter int N       = 64,
  parameter int N_width = 4,
  parameter int P       = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [N-1:0]           cmd_a,
  input  logic [N-1:0]           cmd_b,
  input  logic [2*P-1:0]         cmd_ops,
  input  logic [$clog2(P+1)-1:0] cmd_op_len,
  output logic                   dut_start,
  output logic                   dut_input_enable,
  output logic [N_width-1:0]     dut_a,
  output logic [N_width-1:0]     dut_b,
  output logic [1:0]             dut_op_val,
  input  logic [N_width-1:0]     dut_out,
  input  logic                   dut_output_valid,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [N-1:0]           rsp_data,
  output logic                   rsp_error,
  output logic                   busy
);
  localparam int NIB = N / N_width;
  localparam int CW  = $clog2(NIB) + 1;
  localparam int IW  = CW - 1;
  localparam int LW  = $clog2(P + 1);
  localparam int OW  = (P > 1) ? $clog2(P) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] NIB_LAST = CW'(NIB - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(P);
  localparam logic [LW-1:0] LEN_ONE  = LW'(1);
  localparam logic [OW-1:0] OP_ONE   = OW'(1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);

  typedef enum logic [2:0] {IDLE, START, LOAD, RUN, WAIT, COLLECT, RESP} state_t;
  state_t state, state_next;

  logic [NIB-1:0][N_width-1:0] a_reg, b_reg, data_reg;
  logic [P-1:0][1:0]           ops_reg;
  logic [LW-1:0]               len_reg;
  logic [CW-1:0]               nib_cnt;
  logic [OW-1:0]               op_idx;
  logic [TW-1:0]               wait_cnt;
  logic [IW-1:0]               nib_idx;
  logic                        run_last;

  assign nib_idx  = nib_cnt[IW-1:0];
  assign run_last = (LW'(op_idx) == len_reg - LEN_ONE);
  assign rsp_data = data_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = START;
      START:   state_next = LOAD;
      LOAD:    if (nib_cnt == NIB_LAST) state_next = (len_reg == '0) ? WAIT : RUN;
      RUN:     if (run_last) state_next = WAIT;
      WAIT: begin
        if (dut_output_valid)       state_next = COLLECT;
        else if (wait_cnt == T_LAST) state_next = RESP;
      end
      COLLECT: if (!dut_output_valid || nib_cnt == NIB_LAST) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Nibble counter ends COLLECT at NIB, hence its extra bit; it restarts at 1 after WAIT
  // because the nibble that ends WAIT is already result nibble 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      ops_reg   <= '0;
      len_reg   <= '0;
      nib_cnt   <= '0;
      op_idx    <= '0;
      wait_cnt  <= '0;
      data_reg  <= '0;
      rsp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            a_reg     <= cmd_a;
            b_reg     <= cmd_b;
            ops_reg   <= cmd_ops;
            len_reg   <= (cmd_op_len > LEN_MAX) ? LEN_MAX : cmd_op_len;
            nib_cnt   <= '0;
            op_idx    <= '0;
            wait_cnt  <= '0;
            data_reg  <= '0;
            rsp_error <= 1'b0;
          end
        end
        LOAD: nib_cnt <= (nib_cnt == NIB_LAST) ? '0 : nib_cnt + CNT_ONE;
        RUN:  op_idx <= op_idx + OP_ONE;
        WAIT: begin
          if (dut_output_valid) begin
            data_reg[0] <= dut_out;
            nib_cnt     <= CNT_ONE;
          end else if (wait_cnt == T_LAST) begin
            data_reg  <= '0;
            rsp_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + T_ONE;
          end
        end
        COLLECT: begin
          if (dut_output_valid) begin
            data_reg[nib_idx] <= dut_out;
            nib_cnt           <= nib_cnt + CNT_ONE;
          end else begin
            rsp_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cmd_ready        = 1'b0;
    busy             = 1'b1;
    dut_start        = 1'b0;
    dut_input_enable = 1'b0;
    dut_a            = '0;
    dut_b            = '0;
    dut_op_val       = 2'b00;
    rsp_valid        = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      START: dut_start = 1'b1;
      LOAD: begin
        dut_input_enable = 1'b1;
        dut_a            = a_reg[nib_idx];
        dut_b            = b_reg[nib_idx];
      end
      RUN:           dut_op_val = ops_reg[op_idx];
      WAIT, COLLECT: dut_op_val = 2'b01;
      RESP:          rsp_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fsm_host_bridge.sv
// Bench for fsm_host_bridge: the bench plays the compute FSM, streaming back a result it
// derives from the operand nibbles and opcodes the bridge actually issued.
module tb_fsm_host_bridge;
  localparam int N = 64, NW = 4, P = 8, TIMEOUT = 255;
  localparam int NIB = N / NW;
  localparam int LW  = $clog2(P + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [N-1:0]    cmd_a = '0, cmd_b = '0;
  logic [2*P-1:0]  cmd_ops = '0;
  logic [LW-1:0]   cmd_op_len = '0;
  logic            dut_start, dut_input_enable;
  logic [NW-1:0]   dut_a, dut_b;
  logic [1:0]      dut_op_val;
  logic [NW-1:0]   dut_out = '0;
  logic            dut_output_valid = 1'b0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [N-1:0]    rsp_data;
  logic            rsp_error;
  logic            busy;
  int vectors = 0, miscompares = 0;

  fsm_host_bridge #(.N(N), .N_width(NW), .P(P), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_ops(cmd_ops), .cmd_op_len(cmd_op_len),
    .dut_start(dut_start), .dut_input_enable(dut_input_enable), .dut_a(dut_a), .dut_b(dut_b),
    .dut_op_val(dut_op_val), .dut_out(dut_out), .dut_output_valid(dut_output_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    dut_output_valid = 1'b0;
  endtask

  // One whole transaction from IDLE back to IDLE. burst = number of result nibbles the
  // bench returns (0 = never answers, so wait_cycles must then be TIMEOUT).
  task automatic apply_stimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic [2*P-1:0] ops, input logic [LW-1:0] len,
                                input int wait_cycles, input int burst, input int ready_delay);
    int           eff_len;
    logic [N-1:0] seen_a, seen_b, res, exp_data;
    logic         exp_err;
    eff_len = (int'(len) > P) ? P : int'(len);
    seen_a  = '0;
    seen_b  = '0;
    res     = '0;
    check_output("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    check_output("idle_busy", 64'(busy), 64'd0);
    cmd_valid  = 1'b1;
    cmd_a      = a;
    cmd_b      = b;
    cmd_ops    = ops;
    cmd_op_len = len;
    step();
    cmd_valid  = 1'b0;
    cmd_a      = {$urandom, $urandom};
    cmd_b      = {$urandom, $urandom};
    cmd_ops    = 16'($urandom);
    cmd_op_len = LW'($urandom);
    check_output("start_pulse", 64'({dut_start, dut_input_enable, dut_a, dut_b}), 64'h200);
    check_output("start_cmd_ready", 64'({cmd_ready, busy, rsp_valid}), 64'b010);
    check_output("start_rsp_cleared", 64'({rsp_error, rsp_data}), 64'd0);
    for (int k = 0; k < NIB; k++) begin
      step();
      check_output("load_enable", 64'({dut_start, dut_input_enable, dut_op_val}), 64'b0100);
      seen_a[k*NW +: NW] = dut_a;
      seen_b[k*NW +: NW] = dut_b;
    end
    check_output("load_a", seen_a, a);
    check_output("load_b", seen_b, b);
    // Stand-in arithmetic for the compute FSM; the bridge only has to carry it back intact.
    for (int k = 0; k < eff_len; k++) begin
      step();
      check_output("run_op", 64'(dut_op_val), 64'(ops[2*k +: 2]));
      check_output("run_enable", 64'({dut_input_enable, dut_a, dut_b}), 64'd0);
      case (dut_op_val)
        2'd0:    res = res + seen_a;
        2'd1:    res = res ^ seen_b;
        2'd2:    res = res + seen_a + seen_b;
        default: res = ~res;
      endcase
    end
    for (int c = 0; c < wait_cycles; c++) begin
      step();
      check_output("wait_op", 64'(dut_op_val), 64'd1);
      check_output("wait_idle_outputs", 64'({rsp_valid, dut_input_enable, dut_a, dut_b}), 64'd0);
    end
    for (int k = 0; k < burst; k++) begin
      step();
      check_output("collect_op", 64'(dut_op_val), 64'd1);
      dut_output_valid = 1'b1;
      dut_out          = res[k*NW +: NW];
    end
    if (burst > 0 && burst < NIB) begin
      step();
      check_output("short_no_rsp", 64'(rsp_valid), 64'd0);
    end
    step();
    if (burst == 0) begin
      exp_data = '0;
      exp_err  = 1'b1;
    end else if (burst >= NIB) begin
      exp_data = res;
      exp_err  = 1'b0;
    end else begin
      exp_data = res & ((64'd1 << (burst * NW)) - 64'd1);
      exp_err  = 1'b1;
    end
    for (int c = 0; c <= ready_delay; c++) begin
      if (c > 0) step();
      check_output("resp_valid", 64'({rsp_valid, cmd_ready, busy}), 64'b101);
      check_output("resp_data", rsp_data, exp_data);
      check_output("resp_error", 64'(rsp_error), 64'(exp_err));
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_output("back_idle", 64'({rsp_valid, cmd_ready, busy}), 64'b010);
    check_output("held_data", rsp_data, exp_data);
    check_output("held_error", 64'(rsp_error), 64'(exp_err));
  endtask

  initial begin
    logic [N-1:0] ra;
    $display("[TB] fsm_host_bridge bench starting");
    cmd_valid = 1'b1;
    cmd_a     = {$urandom, $urandom};
    cmd_b     = {$urandom, $urandom};
    cmd_ops   = 16'($urandom);
    repeat (3) begin
      step();
      check_output("reset_cmd_ready", 64'({cmd_ready, busy, rsp_valid, rsp_error}), 64'b1000);
      check_output("reset_dut_outputs",
                   64'({dut_start, dut_input_enable, dut_a, dut_b, dut_op_val}), 64'd0);
      check_output("reset_rsp_data", rsp_data, 64'd0);
    end
    rst = 1'b1;

    apply_stimulus(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 16'h0002, LW'(1), 3, NIB, 0);
    apply_stimulus({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), LW'(0),
                   TIMEOUT, 0, 1);
    apply_stimulus({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), LW'(3), 5, 10, 0);
    apply_stimulus({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), LW'(2), 0, NIB, 20);
    apply_stimulus({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), LW'(8), 2, NIB, 0);
    apply_stimulus({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), LW'(15), 1, NIB, 0);

    // Reset pulled during LOAD cycle 7 must abandon the transaction silently.
    ra         = {$urandom, $urandom};
    cmd_valid  = 1'b1;
    cmd_a      = ra;
    cmd_b      = {$urandom, $urandom};
    cmd_op_len = LW'(2);
    step();
    cmd_valid = 1'b0;
    for (int k = 0; k < 8; k++) step();
    check_output("abort_load7", 64'({dut_input_enable, dut_a}), 64'({1'b1, ra[7*NW +: NW]}));
    rst = 1'b0;
    #1;
    check_output("abort_idle", 64'({cmd_ready, busy, dut_input_enable, dut_start, rsp_valid}),
                 64'b10000);
    repeat (3) begin
      step();
      check_output("abort_no_rsp", 64'({rsp_valid, cmd_ready}), 64'b01);
    end
    rst = 1'b1;
    apply_stimulus({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), LW'(4), 2, NIB, 0);

    for (int t = 0; t < 12; t++) begin
      apply_stimulus({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom),
                     LW'($urandom_range(0, 15)), int'($urandom_range(0, 12)),
                     (t % 4 == 3) ? int'($urandom_range(1, NIB - 1)) : NIB,
                     int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
